// File: rtl/window_5x5.sv
// 5x5 sliding-window generator over a raster pixel stream.
// Four line buffers feed a 5x5 register window; completed windows are held in a single output register.
module window_5x5 #(
   parameter int IMG_WIDTH  = 720,
   parameter int IMG_HEIGHT = 540,
   parameter int DWIDTH_OUT = 200
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DWIDTH_OUT-1:0] out_window,
   output logic                  out_last
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   logic [CW-1:0] col_reg;
   logic [CW-1:0] col_next;
   logic [RW-1:0] row_reg;
   logic [RW-1:0] row_next;
   logic [CW-1:0] rd_addr;
   logic          accept;
   logic          col_end;
   logic          row_end;
   logic          emit;
   logic          last_next;

   logic [7:0]            line_rd [4];
   logic [7:0]            col_in  [5];
   logic [DWIDTH_OUT-1:0] win_reg;
   logic [DWIDTH_OUT-1:0] win_next;

   assign in_ready = !reset && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   assign col_end  = (col_reg == CW'(IMG_WIDTH - 1));
   assign row_end  = (row_reg == RW'(IMG_HEIGHT - 1));

   always_comb begin
      col_next = col_reg;
      row_next = row_reg;
      if (col_end) begin
         col_next = '0;
         row_next = row_end ? '0 : row_reg + RW'(1);
      end else begin
         col_next = col_reg + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (accept) begin
         col_reg <= col_next;
         row_reg <= row_next;
      end
   end

   // Buffers are read one pixel ahead so the registered read already holds
   // the column above the next pixel when it is accepted.
   assign rd_addr = reset ? '0 : (accept ? col_next : col_reg);

   genvar gi;
   genvar gj;
   generate
      for (gi = 0; gi < 4; gi++) begin : gen_line
         logic [7:0] mem [IMG_WIDTH];
         logic [7:0] rd_reg;
         logic [7:0] wr_data;

         if (gi == 0) begin : gen_first
            assign wr_data = in_data;
         end else begin : gen_chain
            assign wr_data = line_rd[gi-1];
         end

         always_ff @(posedge clock) begin
            if (accept) begin
               mem[col_reg] <= wr_data;
            end
            rd_reg <= mem[rd_addr];
         end

         assign line_rd[gi] = rd_reg;
      end

      // Column 4 of the window: oldest line on top, incoming pixel at the bottom.
      for (gi = 0; gi < 4; gi++) begin : gen_col_in
         assign col_in[gi] = line_rd[3-gi];
      end
      assign col_in[4] = in_data;

      for (gi = 0; gi < 5; gi++) begin : gen_win_row
         for (gj = 0; gj < 5; gj++) begin : gen_win_col
            if (gj < 4) begin : gen_shift
               assign win_next[(gi*5+gj)*8 +: 8] = win_reg[(gi*5+gj+1)*8 +: 8];
            end else begin : gen_load
               assign win_next[(gi*5+gj)*8 +: 8] = col_in[gi];
            end
         end
      end

      if (DWIDTH_OUT > 200) begin : gen_pad
         assign win_next[DWIDTH_OUT-1:200] = '0;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (accept) begin
         win_reg <= win_next;
      end
   end

   // Rows 0..3 and columns 0..3 would expose stale or partial data, so no window is emitted there.
   assign emit      = accept && (row_reg >= RW'(4)) && (col_reg >= CW'(4));
   assign last_next = row_end && col_end;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_window <= '0;
      end else if (emit) begin
         out_valid  <= 1'b1;
         out_last   <= last_next;
         out_window <= win_next;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_window_5x5.sv
// Bench for window_5x5: an 8x6 image model builds each expected window directly from pixel coordinates.
module tb_window_5x5;
   localparam int W = 8;
   localparam int H = 6;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         out_valid;
   logic         out_ready;
   logic [199:0] out_window;
   logic         out_last;

   window_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_OUT(200)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_window (out_window),
      .out_last   (out_last)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   logic [7:0]   img [H][W];
   int           mr, mc;
   bit           m_valid, m_last;
   logic [199:0] m_win;
   int           fw, accepted, total_win;
   bit           pat_mode;
   logic [199:0] firsts[$];
   logic [199:0] seconds[$];
   logic [199:0] lasts[$];

   task automatic check(input string tag, input logic [199:0] observed, input logic [199:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [199:0] build(input int r, input int c);
      logic [199:0] v = '0;
      for (int wr = 0; wr < 5; wr++)
         for (int wc = 0; wc < 5; wc++)
            v[(wr*5+wc)*8 +: 8] = img[r-4+wr][c-4+wc];
      return v;
   endfunction

   // One clock: drive, compare at the falling edge, then advance the model.
   task automatic step(input bit iv, input bit ordy, input logic [7:0] d);
      bit exp_ready, consume, acc;
      logic [199:0] w;
      in_valid  = iv;
      out_ready = ordy;
      in_data   = d;
      @(negedge clock);
      exp_ready = !m_valid || ordy;
      check("in_ready", 200'(in_ready), 200'(exp_ready));
      check("out_valid", 200'(out_valid), 200'(m_valid));
      if (m_valid) begin
         check("out_window", out_window, m_win);
         check("out_last", 200'(out_last), 200'(m_last));
      end
      consume = m_valid && ordy;
      acc     = iv && exp_ready;
      if (consume) begin
         w = out_window;
         fw++;
         total_win++;
         if (fw == 1) firsts.push_back(w);
         if (fw == 2) seconds.push_back(w);
         if (out_last) begin
            check("win_per_frame", 200'(fw), 200'(8));
            lasts.push_back(w);
            if (pat_mode) check("last_byte24", 200'(w[199:192]), 200'(8'h57));
            fw = 0;
         end
      end
      if (acc) begin
         img[mr][mc] = d;
         accepted++;
         if (mr >= 4 && mc >= 4) begin
            m_win   = build(mr, mc);
            m_last  = (mr == H-1) && (mc == W-1);
            m_valid = 1'b1;
         end else if (consume) begin
            m_valid = 1'b0;
         end
         if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
         end else begin
            mc++;
         end
      end else if (consume) begin
         m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = 8'h00;
      @(posedge clock);
      #1;
      repeat (2) begin
         @(negedge clock);
         check("rst_in_ready", 200'(in_ready), 200'(0));
         check("rst_out_valid", 200'(out_valid), 200'(0));
         check("rst_out_window", out_window, 200'(0));
         check("rst_out_last", 200'(out_last), 200'(0));
         @(posedge clock);
         #1;
      end
      reset   = 1'b0;
      mr      = 0;
      mc      = 0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      fw      = 0;
   endtask

   task automatic run(input int npix, input bit rand_in, input bit rand_out, input bit rand_data, input int stall);
      int target = accepted + npix;
      int budget = 0;
      int stall_left = stall;
      bit iv, ordy;
      logic [7:0] d;
      while (accepted < target && budget < 20*npix + 100) begin
         iv   = rand_in  ? ($urandom_range(0, 3) != 0) : 1'b1;
         ordy = rand_out ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (stall_left > 0 && m_valid && fw == 0) begin
            ordy = 1'b0;
            stall_left--;
         end
         d = rand_data ? 8'($urandom) : 8'(mr*16 + mc);
         step(iv, ordy, d);
         budget++;
      end
      check("pixel_budget", 200'(accepted >= target), 200'(1));
   endtask

   task automatic drain();
      repeat (4) step(1'b0, 1'b1, 8'h00);
   endtask

   task automatic clear_log();
      firsts.delete();
      seconds.delete();
      lasts.delete();
      total_win = 0;
   endtask

   initial begin
      logic [199:0] w;
      logic [199:0] w2;
      accepted = 0;
      pat_mode = 1'b1;
      do_reset();

      // Full frame, downstream always ready.
      clear_log();
      run(48, 1'b0, 1'b0, 1'b0, 0);
      drain();
      check("a_windows", 200'(total_win), 200'(8));
      check("a_lasts", 200'(lasts.size()), 200'(1));
      w = firsts[0];
      check("a_byte0", 200'(w[7:0]), 200'(8'h00));
      check("a_byte12", 200'(w[103:96]), 200'(8'h22));
      check("a_byte24", 200'(w[199:192]), 200'(8'h44));
      $display("[TB] frame A: %0d windows", total_win);

      // Stall 10 cycles at the first window.
      clear_log();
      run(48, 1'b0, 1'b0, 1'b0, 10);
      drain();
      w = seconds[0];
      check("b_win2_byte24", 200'(w[199:192]), 200'(8'h45));
      check("b_windows", 200'(total_win), 200'(8));
      $display("[TB] frame B (stalled): %0d windows", total_win);

      // Three frames with random handshakes.
      clear_log();
      run(144, 1'b1, 1'b1, 1'b0, 0);
      drain();
      check("c_windows", 200'(total_win), 200'(24));
      check("c_lasts", 200'(lasts.size()), 200'(3));
      $display("[TB] frames C (random handshake): %0d windows", total_win);

      // Abort after pixel (3,2), then a fresh frame.
      clear_log();
      run(27, 1'b0, 1'b0, 1'b0, 0);
      check("d_aborted_windows", 200'(total_win), 200'(0));
      do_reset();
      run(48, 1'b0, 1'b0, 1'b0, 0);
      drain();
      w = firsts[0];
      check("d_byte0", 200'(w[7:0]), 200'(8'h00));
      check("d_byte24", 200'(w[199:192]), 200'(8'h44));
      check("d_windows", 200'(total_win), 200'(8));
      $display("[TB] frame D (after abort): %0d windows", total_win);

      // Back-to-back frames.
      clear_log();
      run(96, 1'b0, 1'b0, 1'b0, 0);
      drain();
      check("e_windows", 200'(total_win), 200'(16));
      w  = firsts[0];
      w2 = firsts[1];
      check("e_first_equal", w2, w);
      $display("[TB] frames E (back-to-back): %0d windows", total_win);

      // Random pixel data with random handshakes.
      pat_mode = 1'b0;
      clear_log();
      run(96, 1'b1, 1'b1, 1'b1, 0);
      drain();
      check("f_windows", 200'(total_win), 200'(16));
      $display("[TB] frames F (random data): %0d windows", total_win);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/window_5x5.md
WINDOW_5X5 -- requirements
Module: window_5x5

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 720, pixels per line (legal range 5..4096).
REQ-002 SHALL have parameter IMG_HEIGHT, default 540, lines per frame (legal range 5..4096).
REQ-003 SHALL have parameter DWIDTH_OUT, default 200, window width in bits (fixed at 8*5*5).
REQ-004 SHALL have port clock  input  1  rising-edge clock; reset reset, synchronous, active-high; clock clock.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream pixel valid.
REQ-007 SHALL have port in_ready  output  1  block accepts pixel this cycle.
REQ-008 SHALL have port in_data  input  8  unsigned pixel, raster order, row 0 col 0 first.
REQ-009 SHALL have port out_valid  output  1  out_window holds a valid window.
REQ-010 SHALL have port out_ready  input  1  downstream accepts window this cycle.
REQ-011 SHALL have port out_window  output  DWIDTH_OUT  packed 5x5 window feeding the 5x5 filter operator.
REQ-012 SHALL have port out_last  output  1  qualifies the final window of a frame.

Function
REQ-013 SHALL accept a pixel when in_valid && in_ready ("accept").
REQ-014 SHALL drive in_ready = !reset && (!out_valid || out_ready) (combinational, single-register skid-free stall).
REQ-015 SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) of the next pixel; col increments per accept, wraps to 0 and increments row at IMG_WIDTH-1.
REQ-016 SHALL wrap row to 0 after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1); the next accept starts a new frame with no idle cycle.
REQ-017 SHALL hold four line buffers of IMG_WIDTH x 8 bits storing the four previous lines, read and written at index col on each accept only.
REQ-018 SHALL hold a 5x5 register window; per accept, shift each window row one column left and load column 4 with {line-4, line-3, line-2, line-1, in_data} top to bottom.
REQ-019 SHALL pack out_window byte k (bits k*8+7:k*8), k = wr*5+wc, as pixel (r-4+wr, c-4+wc), where (r,c) is the accepted pixel completing the window; wr 0 = top, wc 0 = left.
REQ-020 SHALL emit a window only for accepted pixels with r >= 4 and c >= 4 (no padding); output frame is (IMG_WIDTH-4) x (IMG_HEIGHT-4) windows.
REQ-021 SHALL register the window: out_valid rises the cycle after the completing accept (latency 1 clock).
REQ-022 SHALL hold out_window, out_valid, out_last stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid after out_valid && out_ready unless a new window loads in the same cycle (simultaneous drain and load keeps out_valid high with new data).
REQ-024 SHALL assert out_last with the window completed by pixel (IMG_HEIGHT-1, IMG_WIDTH-1) only.
REQ-025 SHALL ignore in_data when in_valid is low or in_ready is low; no state changes on non-accept cycles.
REQ-026 SHALL not use line-buffer contents from a prior frame: the r >= 4 gate suppresses stale windows in rows 0..3.

Reset
REQ-027 SHALL, on reset, set row = 0, col = 0, out_valid = 0, out_last = 0, out_window = 0; in_ready = 0 while reset high.
REQ-028 SHALL not clear line buffers or window registers other than out_window; reset mid-frame discards the partial frame and the next accept is pixel (0,0).

Verification (IMG_WIDTH = 8, IMG_HEIGHT = 6, pixel(r,c) = r*16+c)
REQ-029 SHALL cover: full frame, out_ready = 1 constantly -> exactly 8 windows; first window 1 cycle after accepting (4,4), byte 0 = 0x00, byte 12 = 0x22, byte 24 = 0x44.
REQ-030 SHALL cover: out_ready held low 10 cycles at first window -> out_window stable, in_ready = 0, no pixel lost; window 2 has byte 24 = 0x45 after release.
REQ-031 SHALL cover: random in_valid/out_ready toggling across 3 frames -> window sequence equals reference model; out_last high on exactly the 8th window of each frame, byte 24 = 0x57.
REQ-032 SHALL cover: reset asserted after accepting pixel (3,2), then new frame -> first window again byte 0 = 0x00, byte 24 = 0x44; no window from the aborted frame.
REQ-033 SHALL cover: back-to-back frames without gap -> no window emitted for rows 0..3 of frame 2; frame 2 first window identical to frame 1 first window.
